// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_WAIT     = 3'd7
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int   RW_BIT   = 0;

    // Address byte carries the 7-bit address in [7:1] and R/W in [0].
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_cond_det.sv
// rtl/i2c_cond_det.sv - SCL/SDA synchronizers, SCL edge and START/STOP detection
module i2c_cond_det (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Two synchronizer stages plus one delay stage per line; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign sda_level = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] &  scl_d;
    // SDA may only move while SCL is held high for START/STOP.
    assign start_det =  scl_sync[1] & scl_d &  sda_d & ~sda_sync[1];
    assign stop_det  =  scl_sync[1] & scl_d & ~sda_d &  sda_sync[1];

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - single-address I2C target with byte receive port and read-fetch handshake
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       SCL,
    input  logic       SDA,
    output logic       SDA_pull,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addressed,
    output logic       busy
);

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_cond_det u_cond_det (
        .clk       (clk),
        .rst       (rst),
        .scl       (SCL),
        .sda       (SDA),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [6:0] shreg, shreg_d;
    logic [7:0] tx_shift, tx_shift_d;
    logic       rw, rw_d;
    logic       ack_pend, ack_pend_d;
    logic       pull_d, rx_valid_d, tx_req_d, addressed_d, busy_d;
    logic [7:0] rx_data_d;
    logic [7:0] rx_byte;

    // The byte completed by the current SCL rise.
    assign rx_byte = {shreg, sda_level};

    // Control registers; enable low behaves like reset so the target drops off the bus.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            tx_shift  <= 8'd0;
            rw        <= 1'b0;
            ack_pend  <= 1'b0;
            SDA_pull  <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            addressed <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            tx_shift  <= tx_shift_d;
            rw        <= rw_d;
            ack_pend  <= ack_pend_d;
            SDA_pull  <= pull_d;
            rx_valid  <= rx_valid_d;
            tx_req    <= tx_req_d;
            addressed <= addressed_d;
            busy      <= busy_d;
        end
    end

    // Received byte survives enable going low; only a real reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= 8'h00;
        end else if (enable) begin
            rx_data <= rx_data_d;
        end
    end

    // Next-state logic: STOP, then START, then the per-state SCL-edge handling.
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        tx_shift_d  = tx_shift;
        rw_d        = rw;
        ack_pend_d  = ack_pend;
        pull_d      = SDA_pull;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        addressed_d = addressed;
        busy_d      = busy;

        if (stop_det) begin
            state_d     = ST_IDLE;
            pull_d      = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            ack_pend_d  = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            pull_d      = 1'b0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            ack_pend_d  = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_RX: begin
                    // ack_pend marks "8 bits in, waiting for SCL low to drive the ACK".
                    if (scl_rise && !ack_pend) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == ST_RX) begin
                                rx_data_d  = rx_byte;
                                rx_valid_d = 1'b1;
                                ack_pend_d = 1'b1;
                            end else if (addr_match(rx_byte, ADDR)) begin
                                rw_d       = rx_byte[RW_BIT];
                                ack_pend_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end else if (scl_fall && ack_pend) begin
                        ack_pend_d = 1'b0;
                        pull_d     = 1'b1;
                        if (state == ST_RX) begin
                            state_d = ST_RX_ACK;
                        end else begin
                            state_d     = ST_ADDR_ACK;
                            addressed_d = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw) begin
                            tx_shift_d = tx_data;
                            pull_d     = ~tx_data[7];
                            state_d    = ST_TX;
                        end else begin
                            pull_d  = 1'b0;
                            state_d = ST_RX;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        pull_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RX;
                    end
                end
                ST_TX: begin
                    // bit_cnt counts bits already clocked out; the MSB is on the wire at entry.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            pull_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            tx_shift_d = {tx_shift[6:0], 1'b0};
                            pull_d     = ~tx_shift[6];
                            bit_cnt_d  = bit_cnt + 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise && !ack_pend) begin
                        if (sda_level == I2C_ACK) begin
                            tx_req_d   = 1'b1;
                            ack_pend_d = 1'b1;
                        end else begin
                            state_d     = ST_WAIT;
                            addressed_d = 1'b0;
                        end
                    end else if (scl_fall && ack_pend) begin
                        ack_pend_d = 1'b0;
                        tx_shift_d = tx_data;
                        pull_d     = ~tx_data[7];
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_TX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - self-checking bench for i2c_target with a bus-master model
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst, enable, scl, m_sda_low;
    logic       sda_line, sda_pull, rx_valid, tx_req, addressed, busy;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_seen[$];
    logic [7:0] tx_src[256];
    int         tx_req_cnt = 0;
    int         pull_cnt = 0;
    int         addr_cnt = 0;
    logic [7:0] exp_last_rx = 8'h00;

    always #5 clk = ~clk;

    assign sda_line = ~(m_sda_low | sda_pull);

    i2c_target #(.ADDR(ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .SCL       (scl),
        .SDA       (sda_line),
        .SDA_pull  (sda_pull),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .addressed (addressed),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_seen.push_back(rx_data);
        if (tx_req) begin
            tx_data = tx_src[tx_req_cnt % 256];
            tx_req_cnt = tx_req_cnt + 1;
        end
        if (sda_pull) pull_cnt = pull_cnt + 1;
        if (addressed) addr_cnt = addr_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit model_hit(input logic [7:0] addr_byte);
        return addr_byte[7:1] == ADDR;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic drive_low, output logic sampled);
        m_sda_low = drive_low;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q / 2);
        sampled = sda_line;
        wait_clk(Q / 2);
        scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
        clock_bit(1'b0, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b0, s);
            b[i] = s;
        end
        clock_bit(master_ack, s);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        checks++; if (sda_pull !== 1'b0) begin errors++; $display("FAIL reset_sda_pull: got %b expected 0", sda_pull); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b expected 0", tx_req); end
        checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL reset_addressed: got %b expected 0", addressed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write();
        logic ack;
        int base;
        logic [7:0] d[2];
        d[0] = 8'hA5; d[1] = 8'h3C;
        base = rx_seen.size();
        bus_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start: got %b expected 1", busy); end
        write_byte(8'h84, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b expected 1", ack); end
        checks++; if (addressed !== 1'b1) begin errors++; $display("FAIL write_addressed: got %b expected 1", addressed); end
        for (int i = 0; i < 2; i++) begin
            write_byte(d[i], ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_data_ack%0d: got %b expected 1", i, ack); end
        end
        bus_stop();
        checks++; if (rx_seen.size() - base !== 2) begin errors++; $display("FAIL write_rx_count: got %0d expected 2", rx_seen.size() - base); end
        for (int i = 0; i < 2; i++) begin
            if (rx_seen.size() > base + i) begin
                checks++; if (rx_seen[base + i] !== d[i]) begin errors++; $display("FAIL write_rx_data%0d: got %h expected %h", i, rx_seen[base + i], d[i]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
        checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL write_addressed_stop: got %b expected 0", addressed); end
        exp_last_rx = d[1];
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b;
        int base;
        base = tx_req_cnt;
        tx_src[base % 256] = 8'h5A;
        tx_src[(base + 1) % 256] = 8'hF0;
        bus_start();
        write_byte(8'h85, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b expected 1", ack); end
        read_byte(1'b1, b);
        checks++; if (b !== 8'h5A) begin errors++; $display("FAIL read_byte0: got %h expected 5a", b); end
        read_byte(1'b0, b);
        checks++; if (b !== 8'hF0) begin errors++; $display("FAIL read_byte1: got %h expected f0", b); end
        checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL read_addressed_nack: got %b expected 0", addressed); end
        bus_stop();
        checks++; if (tx_req_cnt - base !== 2) begin errors++; $display("FAIL read_tx_req_count: got %0d expected 2", tx_req_cnt - base); end
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int rb, pb, ab;
        rb = rx_seen.size(); pb = pull_cnt; ab = addr_cnt;
        bus_start();
        write_byte(8'h90, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack); end
        write_byte(8'h5C, ack);
        bus_stop();
        checks++; if (pull_cnt - pb !== 0) begin errors++; $display("FAIL mismatch_pull: got %0d cycles expected 0", pull_cnt - pb); end
        checks++; if (rx_seen.size() - rb !== 0) begin errors++; $display("FAIL mismatch_rx_valid: got %0d expected 0", rx_seen.size() - rb); end
        checks++; if (addr_cnt - ab !== 0) begin errors++; $display("FAIL mismatch_addressed: got %0d cycles expected 0", addr_cnt - ab); end
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] b;
        int base;
        base = tx_req_cnt;
        tx_src[base % 256] = 8'hC7;
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h11, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_data_ack: got %b expected 1", ack); end
        bus_start();
        checks++; if (addressed !== 1'b0) begin errors++; $display("FAIL rstart_addressed_cleared: got %b expected 0", addressed); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstart_busy: got %b expected 1", busy); end
        write_byte(8'h85, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_addr_ack: got %b expected 1", ack); end
        read_byte(1'b0, b);
        checks++; if (b !== 8'hC7) begin errors++; $display("FAIL rstart_read: got %h expected c7", b); end
        bus_stop();
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL rstart_rx_data: got %h expected 11", rx_data); end
        exp_last_rx = 8'h11;
    endtask

    task automatic test_enable_low();
        logic ack;
        int rb, pb, tb;
        rb = rx_seen.size(); pb = pull_cnt; tb = tx_req_cnt;
        enable = 1'b0;
        wait_clk(2);
        bus_start();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_busy: got %b expected 0", busy); end
        write_byte(8'h84, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL enable_addr_ack: got %b expected 0", ack); end
        write_byte(8'h77, ack);
        bus_stop();
        checks++; if (pull_cnt - pb !== 0) begin errors++; $display("FAIL enable_pull: got %0d cycles expected 0", pull_cnt - pb); end
        checks++; if (rx_seen.size() - rb + tx_req_cnt - tb !== 0) begin errors++; $display("FAIL enable_pulses: got %0d expected 0", rx_seen.size() - rb + tx_req_cnt - tb); end
        checks++; if (rx_data !== exp_last_rx) begin errors++; $display("FAIL enable_rx_hold: got %h expected %h", rx_data, exp_last_rx); end
        enable = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_random();
        logic ack, hit;
        logic [6:0] a;
        logic [7:0] addr_byte, b;
        logic [7:0] bytes[3];
        int n, base, tbase;
        for (int it = 0; it < 5; it++) begin
            if ($urandom_range(0, 1) == 1) a = ADDR;
            else begin
                a = 7'($urandom_range(0, 127));
                while (a == ADDR) a = 7'($urandom_range(0, 127));
            end
            addr_byte = {a, 1'b0};
            hit = model_hit(addr_byte);
            n = $urandom_range(1, 3);
            base = rx_seen.size();
            bus_start();
            write_byte(addr_byte, ack);
            checks++; if (ack !== hit) begin errors++; $display("FAIL rand%0d_addr_ack: got %b expected %b", it, ack, hit); end
            for (int k = 0; k < n; k++) begin
                bytes[k] = 8'($urandom);
                write_byte(bytes[k], ack);
                checks++; if (ack !== hit) begin errors++; $display("FAIL rand%0d_data_ack%0d: got %b expected %b", it, k, ack, hit); end
            end
            bus_stop();
            checks++; if (rx_seen.size() - base !== (hit ? n : 0)) begin errors++; $display("FAIL rand%0d_rx_count: got %0d expected %0d", it, rx_seen.size() - base, hit ? n : 0); end
            if (hit) begin
                for (int k = 0; k < n; k++) begin
                    if (rx_seen.size() > base + k) begin
                        checks++; if (rx_seen[base + k] !== bytes[k]) begin errors++; $display("FAIL rand%0d_rx%0d: got %h expected %h", it, k, rx_seen[base + k], bytes[k]); end
                    end
                end
                exp_last_rx = bytes[n - 1];
            end
        end
        tbase = tx_req_cnt;
        for (int k = 0; k < 3; k++) begin
            bytes[k] = 8'($urandom);
            tx_src[(tbase + k) % 256] = bytes[k];
        end
        bus_start();
        write_byte({ADDR, 1'b1}, ack);
        for (int k = 0; k < 3; k++) begin
            read_byte(k < 2, b);
            checks++; if (b !== bytes[k]) begin errors++; $display("FAIL rand_read%0d: got %h expected %h", k, b, bytes[k]); end
        end
        bus_stop();
        checks++; if (tx_req_cnt - tbase !== 3) begin errors++; $display("FAIL rand_tx_req_count: got %0d expected 3", tx_req_cnt - tbase); end
    endtask

    task automatic test_reset_mid_transfer();
        logic ack, s;
        logic [7:0] d;
        int rb, pb, waited;
        d = 8'hC3;
        bus_start();
        write_byte(8'h84, ack);
        for (int i = 7; i >= 0; i--) clock_bit(~d[i], s);
        waited = 0;
        while (sda_pull !== 1'b1 && waited < 20) begin
            wait_clk(1);
            waited++;
        end
        checks++; if (sda_pull !== 1'b1) begin errors++; $display("FAIL rstmid_ack_drive: got %b expected 1", sda_pull); end
        rst = 1'b1;
        wait_clk(1);
        checks++; if (sda_pull !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", sda_pull); end
        rst = 1'b0;
        rb = rx_seen.size(); pb = pull_cnt;
        clock_bit(1'b0, s);
        write_byte(8'h99, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ignored_ack: got %b expected 0", ack); end
        bus_stop();
        checks++; if (rx_seen.size() - rb !== 0) begin errors++; $display("FAIL rstmid_rx_valid: got %0d expected 0", rx_seen.size() - rb); end
        checks++; if (pull_cnt - pb !== 0) begin errors++; $display("FAIL rstmid_pull: got %0d cycles expected 0", pull_cnt - pb); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_repeated_start();
        test_enable_low();
        test_random();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
